// File: rtl/dp_hdr_parser_if.sv
// rtl/dp_hdr_parser_if.sv - AXI-Stream beat bundle observed by the header parser
interface dp_hdr_parser_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master  (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave   (input tdata, tkeep, tvalid, tlast, output tready);
    // Passive tap: sees both sides of the handshake, drives nothing.
    modport monitor (input tdata, tkeep, tvalid, tready, tlast);
endinterface

// File: rtl/dp_hdr_parser.sv
// rtl/dp_hdr_parser.sv - passive Ethernet/IPv4 fixed-header field extractor
module dp_hdr_parser #(
    parameter int          DATA_WIDTH   = 64,
    parameter int          KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter logic [15:0] ETHTYPE_IPV4 = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    dp_hdr_parser_if.monitor s_axis,
    output logic [47:0] parsed_Mac_dest,
    output logic        valid_parsed_Mac_dest,
    output logic [47:0] parsed_Mac_src,
    output logic        valid_parsed_Mac_src,
    output logic [15:0] parsed_ethtype,
    output logic        valid_parsed_ethtype,
    output logic [7:0]  parsed_IHL,
    output logic        valid_parsed_IHL,
    output logic [5:0]  parsed_DSCP,
    output logic        valid_parsed_DSCP,
    output logic [1:0]  parsed_ECN,
    output logic        valid_parsed_ECN,
    output logic [15:0] parsed_Length,
    output logic        valid_parsed_Length,
    output logic [15:0] parsed_Identifiant,
    output logic        valid_parsed_Identifiant,
    output logic [15:0] parsed_Flags_FragmentOffset,
    output logic        valid_parsed_Flags_FragmentOffset,
    output logic [7:0]  parsed_TTL,
    output logic        valid_parsed_TTL,
    output logic [7:0]  parsed_Protocol,
    output logic        valid_parsed_Protocol,
    output logic [15:0] parsed_HeaderChecksum,
    output logic        valid_parsed_HeaderChecksum,
    output logic [31:0] parsed_src_Ipv4,
    output logic        valid_parsed_src_Ipv4,
    output logic [31:0] parsed_dest_Ipv4,
    output logic        valid_parsed_dest_Ipv4,
    output logic        parse_done,
    output logic        busy
);
    localparam int         HDR_BYTES  = 34;
    localparam int         BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] HDR_LAST_BEAT = 3'd4;
    localparam logic [2:0] BEAT_SAT      = 3'd5;

    typedef enum logic [1:0] {IDLE, PARSE, WAIT_LAST} state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic        wr_en, clr_keep;
    logic [2:0]  wr_beat;
    logic        hs;
    logic [7:0]  hdr_q [HDR_BYTES];
    logic [HDR_BYTES-1:0] keep_q;
    logic        eth_ok;

    assign hs = s_axis.tvalid & s_axis.tready;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        clr_keep = 1'b0;
        wr_beat  = beat_q;
        if (hs) begin
            if (s_axis.tlast)           beat_d = 3'd0;
            else if (beat_q < BEAT_SAT) beat_d = beat_q + 3'd1;
        end
        unique case (state_q)
            IDLE: if (hs) begin
                wr_en    = 1'b1;
                clr_keep = 1'b1;
                wr_beat  = 3'd0;
                done_d   = s_axis.tlast;
                state_d  = s_axis.tlast ? IDLE : PARSE;
            end
            PARSE: if (hs) begin
                wr_en = 1'b1;
                // Resolved either by the beat carrying byte 33 or by an early tlast.
                if (beat_q == HDR_LAST_BEAT || s_axis.tlast) begin
                    done_d  = 1'b1;
                    state_d = s_axis.tlast ? IDLE : WAIT_LAST;
                end
            end
            WAIT_LAST: if (hs && s_axis.tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    // Byte-granular capture; keep_q records which header bytes arrived with tkeep set this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_BYTES; i++) hdr_q[i] <= 8'h00;
            keep_q <= '0;
        end else if (wr_en) begin
            if (clr_keep) keep_q <= '0;
            for (int b = 0; b < KEEP_WIDTH; b++) begin
                if (int'(wr_beat) * BEAT_BYTES + b < HDR_BYTES) begin
                    hdr_q[int'(wr_beat) * BEAT_BYTES + b]  <= s_axis.tdata[8*b +: 8];
                    keep_q[int'(wr_beat) * BEAT_BYTES + b] <= s_axis.tkeep[b];
                end
            end
        end
    end

    assign parse_done = done_q;
    assign busy       = (state_q != IDLE);

    assign parsed_Mac_dest = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
    assign parsed_Mac_src  = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
    assign parsed_ethtype  = {hdr_q[12], hdr_q[13]};
    assign parsed_IHL      = {4'b0000, hdr_q[14][3:0]};
    assign parsed_DSCP     = hdr_q[15][7:2];
    assign parsed_ECN      = hdr_q[15][1:0];
    assign parsed_Length   = {hdr_q[16], hdr_q[17]};
    assign parsed_Identifiant          = {hdr_q[18], hdr_q[19]};
    assign parsed_Flags_FragmentOffset = {hdr_q[20], hdr_q[21]};
    assign parsed_TTL            = hdr_q[22];
    assign parsed_Protocol       = hdr_q[23];
    assign parsed_HeaderChecksum = {hdr_q[24], hdr_q[25]};
    assign parsed_src_Ipv4  = {hdr_q[26], hdr_q[27], hdr_q[28], hdr_q[29]};
    assign parsed_dest_Ipv4 = {hdr_q[30], hdr_q[31], hdr_q[32], hdr_q[33]};

    assign valid_parsed_Mac_dest = &keep_q[5:0];
    assign valid_parsed_Mac_src  = &keep_q[11:6];
    assign valid_parsed_ethtype  = &keep_q[13:12];
    assign eth_ok = valid_parsed_ethtype && (parsed_ethtype == ETHTYPE_IPV4);

    assign valid_parsed_IHL                  = eth_ok && keep_q[14];
    assign valid_parsed_DSCP                 = eth_ok && keep_q[15];
    assign valid_parsed_ECN                  = eth_ok && keep_q[15];
    assign valid_parsed_Length               = eth_ok && (&keep_q[17:16]);
    assign valid_parsed_Identifiant          = eth_ok && (&keep_q[19:18]);
    assign valid_parsed_Flags_FragmentOffset = eth_ok && (&keep_q[21:20]);
    assign valid_parsed_TTL                  = eth_ok && keep_q[22];
    assign valid_parsed_Protocol             = eth_ok && keep_q[23];
    assign valid_parsed_HeaderChecksum       = eth_ok && (&keep_q[25:24]);
    assign valid_parsed_src_Ipv4             = eth_ok && (&keep_q[29:26]);
    assign valid_parsed_dest_Ipv4            = eth_ok && (&keep_q[33:30]);
endmodule

// File: tb/tb_dp_hdr_parser.sv
// tb/tb_dp_hdr_parser.sv - bench for dp_hdr_parser against a byte-offset reference model
module tb_dp_hdr_parser;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dp_hdr_parser_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) s_axis_if ();

    logic [47:0] parsed_Mac_dest, parsed_Mac_src;
    logic [15:0] parsed_ethtype, parsed_Length, parsed_Identifiant, parsed_Flags_FragmentOffset;
    logic [15:0] parsed_HeaderChecksum;
    logic [7:0]  parsed_IHL, parsed_TTL, parsed_Protocol;
    logic [5:0]  parsed_DSCP;
    logic [1:0]  parsed_ECN;
    logic [31:0] parsed_src_Ipv4, parsed_dest_Ipv4;
    logic v_mdst, v_msrc, v_eth, v_ihl, v_dscp, v_ecn, v_len, v_id, v_ff, v_ttl, v_pro, v_cs, v_src, v_dst;
    logic parse_done, busy;

    dp_hdr_parser #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .ETHTYPE_IPV4(16'h0800)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis_if),
        .parsed_Mac_dest(parsed_Mac_dest), .valid_parsed_Mac_dest(v_mdst),
        .parsed_Mac_src(parsed_Mac_src), .valid_parsed_Mac_src(v_msrc),
        .parsed_ethtype(parsed_ethtype), .valid_parsed_ethtype(v_eth),
        .parsed_IHL(parsed_IHL), .valid_parsed_IHL(v_ihl),
        .parsed_DSCP(parsed_DSCP), .valid_parsed_DSCP(v_dscp),
        .parsed_ECN(parsed_ECN), .valid_parsed_ECN(v_ecn),
        .parsed_Length(parsed_Length), .valid_parsed_Length(v_len),
        .parsed_Identifiant(parsed_Identifiant), .valid_parsed_Identifiant(v_id),
        .parsed_Flags_FragmentOffset(parsed_Flags_FragmentOffset), .valid_parsed_Flags_FragmentOffset(v_ff),
        .parsed_TTL(parsed_TTL), .valid_parsed_TTL(v_ttl),
        .parsed_Protocol(parsed_Protocol), .valid_parsed_Protocol(v_pro),
        .parsed_HeaderChecksum(parsed_HeaderChecksum), .valid_parsed_HeaderChecksum(v_cs),
        .parsed_src_Ipv4(parsed_src_Ipv4), .valid_parsed_src_Ipv4(v_src),
        .parsed_dest_Ipv4(parsed_dest_Ipv4), .valid_parsed_dest_Ipv4(v_dst),
        .parse_done(parse_done), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int exp_frames = 0;

    // Field table: header byte offset and byte count of each field.
    int    f_off  [14] = '{0, 6, 12, 14, 15, 15, 16, 18, 20, 22, 23, 24, 26, 30};
    int    f_len  [14] = '{6, 6, 2, 1, 1, 1, 2, 2, 2, 1, 1, 2, 4, 4};
    string f_name [14] = '{"Mac_dest", "Mac_src", "ethtype", "IHL", "DSCP", "ECN", "Length",
                           "Identifiant", "Flags_FragOff", "TTL", "Protocol", "HdrChecksum",
                           "src_Ipv4", "dest_Ipv4"};

    logic [7:0] m_byte [34];
    bit         m_keep [34];
    int         m_fidx;
    bit         m_busy;
    logic [7:0] frm [$];
    logic [7:0] f1 [$];
    bit         keep_noise = 1'b0;

    always @(negedge clk) if (parse_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mdl_val(input int i);
        logic [47:0] v = '0;
        for (int j = 0; j < f_len[i]; j++) v = {v[39:0], m_byte[f_off[i] + j]};
        case (i)
            3: v = v & 48'hF;
            4: v = v >> 2;
            5: v = v & 48'h3;
            default: ;
        endcase
        return v;
    endfunction

    function automatic bit mdl_vld(input int i);
        bit ok = 1'b1;
        for (int j = 0; j < f_len[i]; j++) ok = ok && m_keep[f_off[i] + j];
        if (i >= 3) ok = ok && m_keep[12] && m_keep[13] && ({m_byte[12], m_byte[13]} == 16'h0800);
        return ok;
    endfunction

    function automatic logic [47:0] dut_val(input int i);
        case (i)
            0: return parsed_Mac_dest;
            1: return parsed_Mac_src;
            2: return 48'(parsed_ethtype);
            3: return 48'(parsed_IHL);
            4: return 48'(parsed_DSCP);
            5: return 48'(parsed_ECN);
            6: return 48'(parsed_Length);
            7: return 48'(parsed_Identifiant);
            8: return 48'(parsed_Flags_FragmentOffset);
            9: return 48'(parsed_TTL);
            10: return 48'(parsed_Protocol);
            11: return 48'(parsed_HeaderChecksum);
            12: return 48'(parsed_src_Ipv4);
            default: return 48'(parsed_dest_Ipv4);
        endcase
    endfunction

    function automatic logic dut_vld(input int i);
        case (i)
            0: return v_mdst;  1: return v_msrc;  2: return v_eth;  3: return v_ihl;
            4: return v_dscp;  5: return v_ecn;   6: return v_len;  7: return v_id;
            8: return v_ff;    9: return v_ttl;   10: return v_pro; 11: return v_cs;
            12: return v_src;  default: return v_dst;
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < 14; i++) begin
            chk({"val_", f_name[i]}, 64'(dut_val(i)), 64'(mdl_val(i)));
            chk({"vld_", f_name[i]}, 64'(dut_vld(i)), 64'(mdl_vld(i)));
        end
        chk("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 34; i++) begin
            m_byte[i] = 8'h00;
            m_keep[i] = 1'b0;
        end
        m_fidx = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input bit last, output bit exp_done);
        if (m_fidx == 0) for (int i = 0; i < 34; i++) m_keep[i] = 1'b0;
        if (m_fidx <= 4) begin
            for (int b = 0; b < 8; b++) begin
                if (8 * m_fidx + b < 34) begin
                    m_byte[8 * m_fidx + b] = d[8*b +: 8];
                    m_keep[8 * m_fidx + b] = k[b];
                end
            end
        end
        exp_done = (m_fidx == 4) || (last && m_fidx < 4);
        m_busy   = !last;
        m_fidx   = last ? 0 : m_fidx + 1;
    endtask

    task automatic put(input int idx, input logic [7:0] v);
        if (idx < frm.size()) frm[idx] = v;
    endtask

    task automatic build_frame(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input logic [15:0] eth);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        put(12, eth[15:8]);  put(13, eth[7:0]);
        put(14, 8'h45);
        put(16, 8'(16'(len - 14) >> 8)); put(17, 8'(len - 14));
        put(22, 8'h40);      put(23, 8'h06);
        for (int i = 0; i < 4; i++) begin
            put(26 + i, src[31 - 8*i -: 8]);
            put(30 + i, dst[31 - 8*i -: 8]);
        end
    endtask

    // Drives the frame in frm; abort_at >= 0 pulls reset while that beat is presented.
    task automatic send_frame(input bit stall, input int abort_at);
        int nb = (frm.size() + 7) / 8;
        for (int bt = 0; bt < nb; bt++) begin
            logic [63:0] d = '0;
            logic [7:0]  k = '0;
            bit last, ed;
            last = (bt == nb - 1);
            for (int b = 0; b < 8; b++) begin
                if (bt * 8 + b < frm.size()) begin
                    d[8*b +: 8] = frm[bt * 8 + b];
                    k[b] = keep_noise ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
            s_axis_if.tdata  = d;
            s_axis_if.tkeep  = k;
            s_axis_if.tlast  = last;
            s_axis_if.tvalid = 1'b1;
            if (bt == abort_at) begin
                s_axis_if.tready = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                chk("done_in_reset", 64'(parse_done), 64'd0);
                @(posedge clk); #1;
                s_axis_if.tvalid = 1'b0;
                s_axis_if.tlast  = 1'b0;
                rst_n = 1'b1;
                return;
            end
            if (stall && $urandom_range(0, 1) == 1) begin
                s_axis_if.tready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    chk("done_stall", 64'(parse_done), 64'd0);
                    check_all();
                end
            end
            s_axis_if.tready = 1'b1;
            @(posedge clk); #1;
            model_beat(d, k, last, ed);
            check_all();
            chk("parse_done", 64'(parse_done), 64'(ed));
        end
        exp_frames++;
    endtask

    task automatic idle(input int n);
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("done_idle", 64'(parse_done), 64'd0);
            chk("busy_idle", 64'(busy), 64'(m_busy));
        end
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = '0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tready = 1'b1;
        s_axis_if.tlast  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("done_reset", 64'(parse_done), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 64-byte IPv4 frame, back-to-back beats
        build_frame(32'hAC110114, 32'h0A000001, 64, 16'h0800);
        f1 = frm;
        d0 = done_cnt;
        send_frame(1'b0, -1);
        idle(2);
        chk("ipv4_src", 64'(parsed_src_Ipv4), 64'h00000000AC110114);
        chk("ipv4_dst", 64'(parsed_dest_Ipv4), 64'h000000000A000001);
        chk("ipv4_ihl", 64'(parsed_IHL), 64'h05);
        chk("ipv4_ttl", 64'(parsed_TTL), 64'h40);
        chk("ipv4_proto", 64'(parsed_Protocol), 64'h06);
        for (int i = 0; i < 14; i++) chk({"ipv4_allvld_", f_name[i]}, 64'(dut_vld(i)), 64'd1);
        chk("ipv4_done_once", 64'(done_cnt - d0), 64'd1);

        // ARP frame
        build_frame(32'h01020304, 32'h05060708, 42, 16'h0806);
        d0 = done_cnt;
        send_frame(1'b0, -1);
        idle(1);
        chk("arp_ethtype", 64'(parsed_ethtype), 64'h0806);
        chk("arp_eth_vld", 64'(v_eth), 64'd1);
        for (int i = 3; i < 14; i++) chk({"arp_novld_", f_name[i]}, 64'(dut_vld(i)), 64'd0);
        chk("arp_done_once", 64'(done_cnt - d0), 64'd1);

        // 30-byte runt
        build_frame(32'hAC110114, 32'h0A000001, 30, 16'h0800);
        d0 = done_cnt;
        send_frame(1'b0, -1);
        idle(1);
        chk("runt_src_vld", 64'(v_src), 64'd1);
        chk("runt_dst_vld", 64'(v_dst), 64'd0);
        chk("runt_busy", 64'(busy), 64'd0);
        chk("runt_done_once", 64'(done_cnt - d0), 64'd1);

        // Same IPv4 frame with random tready stalls
        frm = f1;
        send_frame(1'b1, -1);
        idle(1);
        chk("stall_src", 64'(parsed_src_Ipv4), 64'h00000000AC110114);
        chk("stall_dst", 64'(parsed_dest_Ipv4), 64'h000000000A000001);
        chk("stall_dst_vld", 64'(v_dst), 64'd1);

        // Reset during beat 2, then a fresh frame
        frm = f1;
        send_frame(1'b0, 2);
        idle(1);
        frm = f1;
        send_frame(1'b0, -1);
        idle(1);
        chk("post_rst_src", 64'(parsed_src_Ipv4), 64'h00000000AC110114);
        chk("post_rst_src_vld", 64'(v_src), 64'd1);

        // Two frames back-to-back
        d0 = done_cnt;
        frm = f1;
        send_frame(1'b0, -1);
        build_frame(32'hC0A80001, 32'h0A000002, 64, 16'h0800);
        send_frame(1'b0, -1);
        idle(2);
        chk("b2b_src", 64'(parsed_src_Ipv4), 64'h00000000C0A80001);
        chk("b2b_done_two", 64'(done_cnt - d0), 64'd2);

        // Randomized frames: length, ethtype, keep holes, stalls, gaps
        repeat (14) begin
            build_frame($urandom, $urandom, $urandom_range(1, 80),
                        ($urandom_range(0, 1) == 1) ? 16'h0800 : 16'($urandom));
            keep_noise = ($urandom_range(0, 2) == 0);
            send_frame(1'(($urandom_range(0, 1))), -1);
            keep_noise = 1'b0;
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk("done_total", 64'(done_cnt), 64'(exp_frames));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dp_hdr_parser.md
Name: dp_hdr_parser

Overview:
- Passive header parser for the simple IPv4 firewall data path. It sits directly upstream of the match-action stage.
- It taps a 64-bit AXI-Stream receive path without driving any stream signal, and captures the Ethernet and IPv4 fixed-header fields of each frame into registers.
- It raises a per-field valid flag once each field is complete, and pulses parse_done when the header is resolved.
- Field outputs and their valid flags connect one-to-one to the match-action parsed_* / valid_parsed_* inputs.

Parameters:
- DATA_WIDTH, 64: stream data width. Only 64 is supported.
- KEEP_WIDTH, 8: DATA_WIDTH/8.
- ETHTYPE_IPV4, 16'h0800: ethtype that enables the IPv4 field valids.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  64  observed beat data; byte n of the beat is on tdata[8n+7:8n].
- s_axis_tkeep  in  8  observed byte enables.
- s_axis_tvalid  in  1  observed valid.
- s_axis_tready  in  1  observed ready. A beat counts only when tvalid&tready.
- s_axis_tlast  in  1  observed last beat.
- parsed_Mac_dest / parsed_Mac_src  out  48 each, with valid_* out 1 each.
- parsed_ethtype  out  16, with valid_parsed_ethtype  out  1.
- parsed_IHL  out  8  {4'b0, header byte 14[3:0]}, with valid  out  1.
- parsed_DSCP 6, parsed_ECN 2, parsed_Length 16, parsed_Identifiant 16, parsed_Flags_FragmentOffset 16, parsed_TTL 8, parsed_Protocol 8, parsed_HeaderChecksum 16, parsed_src_Ipv4 32, parsed_dest_Ipv4 32  out  each with a valid_* out 1.
- parse_done  out  1  one-cycle pulse when the header has been resolved.
- busy  out  1  high from the first beat of a frame until its tlast.

Behaviour:
- Reset (async, rst_n=0): all field outputs, all valids, parse_done and busy go to 0; beat counter goes to 0; FSM goes to IDLE.
  - Reset mid-frame abandons that frame.
  - The first handshake after rst_n rises is treated as beat 0 of a new frame.
- Header byte offsets, multi-byte fields big-endian, lower offset = MSB:
  - Mac_dest 0-5, Mac_src 6-11, ethtype 12-13
  - ver/IHL 14, DSCP = byte15[7:2], ECN = byte15[1:0]
  - Length 16-17, Identifiant 18-19, Flags_FragmentOffset 20-21
  - TTL 22, Protocol 23, HeaderChecksum 24-25
  - src 26-29, dest 30-33
- Beat k carries header bytes 8k..8k+7. A 3-bit beat counter increments per handshake and saturates at 5; it clears to 0 on a handshake with tlast.
- FSM:
  - IDLE: on handshake, load beat 0 and set busy. Go to PARSE, or to IDLE if tlast is set on that beat.
  - PARSE: load beats 1-4. When the beat containing byte 33 is accepted, pulse parse_done and go to WAIT_LAST (or IDLE if tlast). A tlast handshake before byte 33 pulses parse_done and goes to IDLE.
  - WAIT_LAST: ignore data. A tlast handshake clears busy and returns to IDLE.
- Field registers update on the cycle after the handshake that delivers their bytes.
  - A field's valid rises together with its last byte, only if every byte of the field had tkeep=1.
- IPv4 field valids additionally require valid_parsed_ethtype && parsed_ethtype==ETHTYPE_IPV4. For a non-IPv4 frame, the IPv4 fields may update but their valids stay 0.
- Every valid flag clears on the beat-0 handshake of the next frame; field values hold until overwritten.
- Flags that are valid stay valid through the parse_done pulse and until the next frame's beat 0.
- parse_done fires exactly once per frame, in the cycle after the resolving handshake.
- Runt frame: fields not fully received keep valid=0; parse_done still pulses.
- tvalid without tready is not a handshake; nothing changes. Handshakes may occur on back-to-back cycles.
- A handshake with tlast followed immediately by the next frame's beat 0 is handled with no bubble.

Test Plan:
- 64-byte IPv4 frame, src 172.17.1.20, dest 10.0.0.1, ethtype 0x0800, IHL 5, TTL 64, Protocol 6, back-to-back beats:
  - parsed_src_Ipv4=32'hAC110114, parsed_dest_Ipv4=32'h0A000001, parsed_IHL=8'h05, parsed_TTL=8'h40; all valids=1.
  - parse_done pulses once, the cycle after beat 4; busy drops the cycle after tlast.
- ARP frame (ethtype 0x0806): parsed_ethtype=16'h0806 with its valid=1; every IPv4 valid stays 0; parse_done pulses once.
- 30-byte runt (beat 3 with tlast, tkeep=8'h3F):
  - src_Ipv4 valid=1, dest_Ipv4 valid=0.
  - parse_done pulses after beat 3; FSM returns to IDLE.
- Same frame with tready deasserted randomly for 1-3 cycles: field values and valid timing follow the handshakes; output equals the stall-free case.
- rst_n asserted during beat 2:
  - All outputs go to 0 immediately.
  - After release, a fresh IPv4 frame parses correctly with src 172.17.1.20.
- Two frames back-to-back (tlast, then beat 0 on the next cycle), second src 192.168.0.1:
  - Valids clear at the second frame's beat 0.
  - parsed_src_Ipv4 becomes 32'hC0A80001; two parse_done pulses total.
